// File: rtl/load_writeback_unit.sv
// rtl/load_writeback_unit.sv - load return FIFO with register write-back and per-warp pending tracking
// Returned load packets queue here until the register-file write port is granted.
module load_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WARP_W = 3,
  parameter int LANES  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadIssue_i,
  input  logic [WARP_W-1:0]         loadIssueWarp_i,
  input  logic                      loadPacketValid_i,
  input  logic [WARP_W-1:0]         loadWarp_i,
  input  logic [LANES-1:0]          loadMask_i,
  input  logic [REG_W-1:0]          loadReg_i,
  input  logic [LANES*DATA_W-1:0]   loadData_i,
  input  logic                      wbGrant_i,
  output logic                      wbValid_o,
  output logic [WARP_W-1:0]         wbWarp_o,
  output logic [REG_W-1:0]          wbReg_o,
  output logic [LANES-1:0]          wbMask_o,
  output logic [LANES*DATA_W-1:0]   wbData_o,
  output logic [(1<<WARP_W)-1:0]    pending_o,
  output logic                      full_o,
  output logic                      err_o
);

  localparam int NWARP = 1 << WARP_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(DEPTH - 1);

  logic [WARP_W-1:0]       warpMem [DEPTH];
  logic [LANES-1:0]        maskMem [DEPTH];
  logic [REG_W-1:0]        regMem  [DEPTH];
  logic [LANES*DATA_W-1:0] dataMem [DEPTH];

  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          fifoFull, pop, push, overflow;

  logic [2:0]       cnt     [NWARP];
  logic [2:0]       cntNext [NWARP];
  logic [NWARP-1:0] incVec, decVec;
  logic             cntErr;

  assign wbValid_o = (count != '0);
  assign fifoFull  = (count == DEPTH_C);
  assign full_o    = (count >= ALMOST_C);
  assign pop       = wbValid_o && wbGrant_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = loadPacketValid_i && (!fifoFull || pop);
  assign overflow  = loadPacketValid_i && fifoFull && !pop;

  // Gate the head with valid so an empty FIFO presents zeros rather than stale entries.
  assign wbWarp_o = wbValid_o ? warpMem[rdPtr] : '0;
  assign wbReg_o  = wbValid_o ? regMem[rdPtr]  : '0;
  assign wbMask_o = wbValid_o ? maskMem[rdPtr] : '0;
  assign wbData_o = wbValid_o ? dataMem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      warpMem[wrPtr] <= loadWarp_i;
      maskMem[wrPtr] <= loadMask_i;
      regMem[wrPtr]  <= loadReg_i;
      dataMem[wrPtr] <= loadData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    incVec = '0;
    decVec = '0;
    cntErr = 1'b0;
    if (loadIssue_i) incVec[loadIssueWarp_i] = 1'b1;
    if (pop)         decVec[wbWarp_o]        = 1'b1;
    for (int w = 0; w < NWARP; w++) begin
      cntNext[w] = cnt[w];
      // Saturate at both ends instead of wrapping; the attempt is flagged as an error.
      case ({incVec[w], decVec[w]})
        2'b10: begin
          if (cnt[w] == 3'd7) cntErr = 1'b1;
          else                cntNext[w] = cnt[w] + 3'd1;
        end
        2'b01: begin
          if (cnt[w] == 3'd0) cntErr = 1'b1;
          else                cntNext[w] = cnt[w] - 3'd1;
        end
        default: cntNext[w] = cnt[w];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NWARP; w++) cnt[w] <= 3'd0;
      err_o <= 1'b0;
    end else begin
      cnt <= cntNext;
      if (cntErr || overflow) err_o <= 1'b1;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int w = 0; w < NWARP; w++) pending_o[w] = (cnt[w] != 3'd0);
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb/tb_load_writeback_unit.sv - scoreboard bench for load_writeback_unit
module tb_load_writeback_unit;

  typedef struct packed {
    logic [2:0]   warp;
    logic [4:0]   rg;
    logic [7:0]   mask;
    logic [255:0] data;
  } pkt_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         loadIssue;
  logic [2:0]   loadIssueWarp;
  logic         loadPacketValid;
  logic [2:0]   loadWarp;
  logic [7:0]   loadMask;
  logic [4:0]   loadReg;
  logic [255:0] loadData;
  logic         wbGrant;
  logic         wbValid;
  logic [2:0]   wbWarp;
  logic [4:0]   wbReg;
  logic [7:0]   wbMask;
  logic [255:0] wbData;
  logic [7:0]   pending;
  logic         full;
  logic         err;

  int   checks = 0;
  int   errors = 0;
  pkt_t sbQ[$];

  load_writeback_unit dut (
    .clk(clk), .reset(reset),
    .loadIssue_i(loadIssue), .loadIssueWarp_i(loadIssueWarp),
    .loadPacketValid_i(loadPacketValid), .loadWarp_i(loadWarp),
    .loadMask_i(loadMask), .loadReg_i(loadReg), .loadData_i(loadData),
    .wbGrant_i(wbGrant), .wbValid_o(wbValid), .wbWarp_o(wbWarp),
    .wbReg_o(wbReg), .wbMask_o(wbMask), .wbData_o(wbData),
    .pending_o(pending), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mkData(input int seed);
    logic [255:0] d;
    for (int l = 0; l < 8; l++) d[l*32 +: 32] = 32'hA500_0000 | 32'(seed * 16 + l);
    return d;
  endfunction

  task automatic drivePkt(input logic [2:0] w, input logic [4:0] r, input logic [7:0] m,
                          input int seed, input bit accepted);
    pkt_t p;
    loadPacketValid = 1'b1;
    loadWarp = w;
    loadReg  = r;
    loadMask = m;
    loadData = mkData(seed);
    p.warp = w; p.rg = r; p.mask = m; p.data = mkData(seed);
    if (accepted) sbQ.push_back(p);
  endtask

  // Monitor: every granted head entry must match the oldest expected packet.
  always @(negedge clk) begin
    if (!reset && wbValid && wbGrant) begin
      if (sbQ.size() == 0) begin
        chk("unexpected_wb", 64'(wbWarp), 64'hFFFF);
      end else begin
        pkt_t e;
        e = sbQ.pop_front();
        chk("wb_warp", 64'(wbWarp), 64'(e.warp));
        chk("wb_reg",  64'(wbReg),  64'(e.rg));
        chk("wb_mask", 64'(wbMask), 64'(e.mask));
        for (int l = 0; l < 8; l++)
          chk($sformatf("wb_lane%0d", l), 64'(wbData[l*32 +: 32]), 64'(e.data[l*32 +: 32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; loadIssue = 1'b0; loadIssueWarp = '0; loadPacketValid = 1'b0;
    loadWarp = '0; loadMask = '0; loadReg = '0; loadData = '0; wbGrant = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wbValid", 64'(wbValid), 0);
    chk("rst_wbWarp",  64'(wbWarp), 0);
    chk("rst_wbReg",   64'(wbReg), 0);
    chk("rst_wbMask",  64'(wbMask), 0);
    chk("rst_wbData",  64'(wbData[63:0]), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_full",    64'(full), 0);
    chk("rst_err",     64'(err), 0);
    tick();
    reset = 1'b0;

    // Basic flow: issue warp 2 in cycle 0, return in cycle 3, grant held.
    wbGrant = 1'b1;
    loadIssue = 1'b1; loadIssueWarp = 3'd2;
    tick();
    loadIssue = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) drivePkt(3'd2, 5'd5, 8'hFF, 1, 1'b1);
      @(negedge clk);
      chk($sformatf("basic_pending_c%0d", c), 64'(pending[2]), 1);
      chk($sformatf("basic_valid_c%0d", c), 64'(wbValid), (c == 4) ? 1 : 0);
      if (c == 4) chk("basic_reg", 64'(wbReg), 5);
      tick();
      loadPacketValid = 1'b0;
    end
    @(negedge clk);
    chk("basic_pending_c5", 64'(pending[2]), 0);
    chk("basic_valid_c5", 64'(wbValid), 0);
    chk("basic_err", 64'(err), 0);

    // Stall and fill with grant low; fifth packet overflows.
    wbGrant = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      drivePkt(3'(4 + i), 5'(1 + i), (i == 1) ? 8'h00 : 8'(8'h0F << i), 10 + i, 1'b1);
      @(negedge clk);
      chk($sformatf("fill_full_%0d", i), 64'(full), (i >= 3) ? 1 : 0);
      tick();
    end
    drivePkt(3'd1, 5'd9, 8'hAA, 20, 1'b0);
    @(negedge clk);
    chk("fill_full_4", 64'(full), 1);
    chk("fill_err_before", 64'(err), 0);
    tick();
    loadPacketValid = 1'b0;
    @(negedge clk);
    chk("overflow_err", 64'(err), 1);
    chk("overflow_head_warp", 64'(wbWarp), 4);
    chk("overflow_head_reg", 64'(wbReg), 1);
    tick();
    @(negedge clk);
    chk("stall_head_stable", 64'(wbReg), 1);
    chk("stall_head_data", 64'(wbData[31:0]), 64'(32'hA500_0000 | 32'(10 * 16)));

    // Full FIFO with simultaneous push and pop keeps occupancy at DEPTH.
    wbGrant = 1'b1;
    drivePkt(3'd3, 5'd10, 8'h81, 30, 1'b1);
    tick();
    loadPacketValid = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) chk("swap_full", 64'(full), 1);
      if (wbValid) n++;
      tick();
    end
    chk("swap_drain_len", 64'(n), 4);
    chk("err_sticky", 64'(err), 1);

    // Counter saturation on warp 1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wbGrant = 1'b0;
    loadIssue = 1'b1; loadIssueWarp = 3'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) begin
        @(negedge clk);
        chk("sat_err_at7", 64'(err), 0);
        #4;
      end
    end
    loadIssue = 1'b0;
    @(negedge clk);
    chk("sat_err", 64'(err), 1);
    chk("sat_pending", 64'(pending), 8'h02);
    wbGrant = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      drivePkt(3'd1, 5'(i), 8'h01, 40 + i, 1'b1);
      tick();
    end
    loadPacketValid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("sat_after6", 64'(pending[1]), 1);
    drivePkt(3'd1, 5'd6, 8'h01, 46, 1'b1);
    tick();
    loadPacketValid = 1'b0;
    tick();
    @(negedge clk);
    chk("sat_after7", 64'(pending[1]), 0);

    // Same-cycle increment and decrement on warp 0.
    loadIssue = 1'b1; loadIssueWarp = 3'd0;
    tick();
    loadIssue = 1'b0;
    drivePkt(3'd0, 5'd12, 8'h3C, 50, 1'b1);
    tick();
    loadPacketValid = 1'b0;
    loadIssue = 1'b1; loadIssueWarp = 3'd0;
    tick();
    loadIssue = 1'b0;
    @(negedge clk);
    chk("incdec_pending", 64'(pending[0]), 1);
    drivePkt(3'd0, 5'd13, 8'hC3, 51, 1'b1);
    tick();
    loadPacketValid = 1'b0;
    tick();
    @(negedge clk);
    chk("incdec_final", 64'(pending[0]), 0);

    // Mid-operation reset with three entries queued and pending 0x0F.
    wbGrant = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      loadIssue = 1'b1; loadIssueWarp = 3'(i);
      if (i < 3) drivePkt(3'(i), 5'(20 + i), 8'hF0, 60 + i, 1'b1);
      else       loadPacketValid = 1'b0;
      tick();
    end
    loadIssue = 1'b0;
    @(negedge clk);
    chk("pre_rst_pending", 64'(pending), 8'h0F);
    chk("pre_rst_full", 64'(full), 1);
    chk("pre_rst_err", 64'(err), 1);
    reset = 1'b1;
    loadIssue = 1'b1; loadIssueWarp = 3'd5;
    drivePkt(3'd5, 5'd30, 8'hFF, 70, 1'b0);
    sbQ.delete();
    tick();
    reset = 1'b0; loadIssue = 1'b0; loadPacketValid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(wbValid), 0);
    chk("mid_rst_pending", 64'(pending), 0);
    chk("mid_rst_full", 64'(full), 0);
    chk("mid_rst_err", 64'(err), 0);

    // Decrement of an idle warp flags an error.
    wbGrant = 1'b1;
    tick();
    drivePkt(3'd3, 5'd7, 8'h55, 80, 1'b1);
    tick();
    loadPacketValid = 1'b0;
    @(negedge clk);
    chk("underflow_err_before", 64'(err), 0);
    tick();
    @(negedge clk);
    chk("underflow_err", 64'(err), 1);
    chk("underflow_pending", 64'(pending), 0);

    repeat (3) tick();
    chk("sb_drained", 64'(sbQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
